// File: rtl/pmt_scan_cmd_tx_if.sv
// Valid/ready message link to the PMT board comm port plus its acknowledge return path.
// Signal names carry the transmitter's point of view; the modports fix the actual directions.
interface pmt_scan_cmd_tx_if;
  logic [15:0] tx_data_o;
  logic        tx_vld_o;
  logic        tx_rdy_i;
  logic        ack_vld_i;
  logic [1:0]  ack_ch_i;
  logic [3:0]  ack_seq_i;

  modport master (
    output tx_data_o, tx_vld_o,
    input  tx_rdy_i, ack_vld_i, ack_ch_i, ack_seq_i
  );

  modport slave (
    input  tx_data_o, tx_vld_o,
    output tx_rdy_i, ack_vld_i, ack_ch_i, ack_seq_i
  );
endinterface

// File: rtl/pmt_scan_cmd_tx.sv
// Frames per-PMT scan command updates into sequenced 16-bit messages, sends them over a
// valid/ready link, and retransmits until acknowledged or the retry budget runs out.
module pmt_scan_cmd_tx #(
  parameter real         TCQ         = 0.1,
  parameter int unsigned ACK_TIMEOUT = 'd10000,
  parameter int unsigned MAX_RETRY   = 'd3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [3:0]        pmt_scan_cmd_sel_i,
  input  logic [3:0]        pmt_scan_cmd_i,
  pmt_scan_cmd_tx_if.master link,
  output logic [2:0]        err_o,
  input  logic              err_clr_i,
  output logic              busy_o
);

  localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK} state_t;

  state_t          state_q, state_d;
  logic [2:0]      pend_q;
  logic [2:0][3:0] pend_cmd_q;
  logic [2:0]      pend_acc_q;
  logic [2:0][3:0] seq_q;
  logic [1:0]      rr_ptr_q;
  logic [1:0]      cur_ch_q;
  logic [15:0]     frame_q;
  logic [RW-1:0]   retry_q;
  logic [TW-1:0]   timer_q;
  logic [2:0]      err_q;

  logic            grant_vld;
  logic [1:0]      grant_ch;
  logic [1:0]      cand;
  logic            ack_match;
  logic            load_frame, accept, acked, retry, give_up;

  // Round-robin pick: scan from the pointer upward so the lowest offset wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = 2'd0;
    cand      = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      cand = 2'((int'(rr_ptr_q) + k) % 3);
      if (pend_q[cand]) begin
        grant_vld = 1'b1;
        grant_ch  = cand;
      end
    end
  end

  assign ack_match = link.ack_vld_i && (link.ack_ch_i == cur_ch_q) &&
                     (link.ack_seq_i == frame_q[7:4]);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    load_frame = 1'b0;
    accept     = 1'b0;
    acked      = 1'b0;
    retry      = 1'b0;
    give_up    = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          load_frame = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (link.tx_rdy_i) begin
          accept  = 1'b1;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // A matching ack in the timeout cycle beats the timeout.
        if (ack_match) begin
          acked   = 1'b1;
          state_d = IDLE;
        end else if (timer_q == TIMER_LAST) begin
          if (retry_q < RETRY_MAX) begin
            retry   = 1'b1;
            state_d = SEND;
          end else begin
            give_up = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q     <= '0;
      pend_cmd_q <= '0;
      pend_acc_q <= '0;
      seq_q      <= '0;
      rr_ptr_q   <= '0;
      cur_ch_q   <= '0;
      frame_q    <= '0;
      retry_q    <= '0;
      timer_q    <= '0;
      err_q      <= '0;
    end else begin
      if (load_frame) begin
        pend_q[grant_ch] <= 1'b0;
        frame_q  <= {4'hA, pend_acc_q[grant_ch], grant_ch, 1'b0,
                     seq_q[grant_ch], pend_cmd_q[grant_ch]};
        cur_ch_q <= grant_ch;
        rr_ptr_q <= (grant_ch == 2'd2) ? 2'd0 : grant_ch + 2'd1;
        retry_q  <= '0;
      end
      // Captures come after the grant clear so a same-cycle update keeps the slot pending.
      for (int i = 0; i < 3; i++) begin
        if (pmt_scan_cmd_sel_i[i]) begin
          pend_q[i]     <= 1'b1;
          pend_cmd_q[i] <= pmt_scan_cmd_i;
          pend_acc_q[i] <= pmt_scan_cmd_sel_i[3];
        end
      end
      if (accept)                     timer_q <= '0;
      else if (state_q == WAIT_ACK)   timer_q <= timer_q + TW'(1);
      if (retry) begin
        retry_q    <= retry_q + RW'(1);
        frame_q[8] <= 1'b1;
      end
      if (acked || give_up) seq_q[cur_ch_q] <= seq_q[cur_ch_q] + 4'd1;
      err_q <= (err_clr_i ? 3'b000 : err_q) | (give_up ? (3'b001 << cur_ch_q) : 3'b000);
    end
  end

  assign link.tx_vld_o  = (state_q == SEND);
  assign link.tx_data_o = frame_q;
  assign err_o          = err_q;
  assign busy_o         = (state_q != IDLE) || (|pend_q);

endmodule

// File: tb/tb_pmt_scan_cmd_tx.sv
// Directed bench for pmt_scan_cmd_tx: a per-cycle vector table for the basic flows, then
// hand-written sequences for timeout/retry, ack/timeout collision and reset mid-send.
module tb_pmt_scan_cmd_tx;

  typedef struct {
    logic        rst;
    logic [3:0]  sel;
    logic [3:0]  cmd;
    logic        rdy;
    logic        av;
    logic [1:0]  ach;
    logic [3:0]  aseq;
    logic        clr;
    logic        evld;
    logic [15:0] edata;
    logic        ebusy;
    logic [2:0]  eerr;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sel, cmd;
  logic [2:0] err;
  logic       err_clr;
  logic       busy;
  int         checks = 0;
  int         errors = 0;
  vec_t       vec[$];

  pmt_scan_cmd_tx_if link();

  pmt_scan_cmd_tx #(
    .ACK_TIMEOUT(16),
    .MAX_RETRY  (3)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .pmt_scan_cmd_sel_i(sel),
    .pmt_scan_cmd_i    (cmd),
    .link              (link),
    .err_o             (err),
    .err_clr_i         (err_clr),
    .busy_o            (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic r, input logic [3:0] s, input logic [3:0] c,
                              input logic rd, input logic a, input logic [1:0] ac,
                              input logic [3:0] aq, input logic cl, input logic ev,
                              input logic [15:0] ed, input logic eb, input logic [2:0] ee);
    vec_t v;
    v.rst = r; v.sel = s; v.cmd = c; v.rdy = rd; v.av = a; v.ach = ac; v.aseq = aq;
    v.clr = cl; v.evld = ev; v.edata = ed; v.ebusy = eb; v.eerr = ee;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    rst               = v.rst;
    sel               = v.sel;
    cmd               = v.cmd;
    link.tx_rdy_i     = v.rdy;
    link.ack_vld_i    = v.av;
    link.ack_ch_i     = v.ach;
    link.ack_seq_i    = v.aseq;
    err_clr           = v.clr;
    checkOutput($sformatf("row%0d_vld", idx), {15'd0, link.tx_vld_o}, {15'd0, v.evld});
    checkOutput($sformatf("row%0d_busy", idx), {15'd0, busy}, {15'd0, v.ebusy});
    checkOutput($sformatf("row%0d_err", idx), {13'd0, err}, {13'd0, v.eerr});
    if (v.evld)
      checkOutput($sformatf("row%0d_data", idx), link.tx_data_o, v.edata);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic waitVld(input int budget, output int cycles);
    cycles = 0;
    while (link.tx_vld_o !== 1'b1 && cycles < budget) begin
      step();
      cycles++;
    end
    checkOutput("vld_wait", {15'd0, link.tx_vld_o}, 16'd1);
  endtask

  initial begin
    int gap;
    int extra;

    rst = 1'b1; sel = '0; cmd = '0; err_clr = 1'b0;
    link.tx_rdy_i = 1'b0; link.ack_vld_i = 1'b0; link.ack_ch_i = '0; link.ack_seq_i = '0;
    repeat (3) step();
    checkOutput("reset_vld", {15'd0, link.tx_vld_o}, 16'd0);
    checkOutput("reset_data", link.tx_data_o, 16'h0000);
    checkOutput("reset_busy", {15'd0, busy}, 16'd0);
    checkOutput("reset_err", {13'd0, err}, 16'd0);

    // single send to ch0, ack after a few cycles
    vec.push_back(mk(0,4'h1,4'h1,1,0,0,0,0, 0,16'h0000,0,0));
    vec.push_back(mk(0,4'h0,4'h0,1,0,0,0,0, 0,16'h0000,1,0));
    vec.push_back(mk(0,4'h0,4'h0,1,0,0,0,0, 1,16'hA001,1,0));
    vec.push_back(mk(0,4'h0,4'h0,1,0,0,0,0, 0,16'h0000,1,0));
    vec.push_back(mk(0,4'h0,4'h0,1,0,0,0,0, 0,16'h0000,1,0));
    vec.push_back(mk(0,4'h0,4'h0,1,0,0,0,0, 0,16'h0000,1,0));
    vec.push_back(mk(0,4'h0,4'h0,1,0,0,0,0, 0,16'h0000,1,0));
    vec.push_back(mk(0,4'h0,4'h0,1,1,0,0,0, 0,16'h0000,1,0));
    vec.push_back(mk(0,4'h0,4'h0,1,0,0,0,0, 0,16'h0000,0,0));
    // round-robin after reset, then ch0 again with seq 1
    vec.push_back(mk(1,4'h0,4'h0,1,0,0,0,0, 0,16'h0000,0,0));
    vec.push_back(mk(0,4'hF,4'h2,1,0,0,0,0, 0,16'h0000,0,0));
    vec.push_back(mk(0,4'h0,4'h0,1,0,0,0,0, 0,16'h0000,1,0));
    vec.push_back(mk(0,4'h0,4'h0,1,0,0,0,0, 1,16'hA802,1,0));
    vec.push_back(mk(0,4'h0,4'h0,1,1,0,0,0, 0,16'h0000,1,0));
    vec.push_back(mk(0,4'h0,4'h0,1,0,0,0,0, 0,16'h0000,1,0));
    vec.push_back(mk(0,4'h0,4'h0,1,0,0,0,0, 1,16'hAA02,1,0));
    vec.push_back(mk(0,4'h0,4'h0,1,1,1,0,0, 0,16'h0000,1,0));
    vec.push_back(mk(0,4'h0,4'h0,1,0,0,0,0, 0,16'h0000,1,0));
    vec.push_back(mk(0,4'h0,4'h0,1,0,0,0,0, 1,16'hAC02,1,0));
    vec.push_back(mk(0,4'h0,4'h0,1,1,2,0,0, 0,16'h0000,1,0));
    vec.push_back(mk(0,4'h1,4'h1,1,0,0,0,0, 0,16'h0000,0,0));
    vec.push_back(mk(0,4'h0,4'h0,1,0,0,0,0, 0,16'h0000,1,0));
    vec.push_back(mk(0,4'h0,4'h0,1,0,0,0,0, 1,16'hA011,1,0));
    vec.push_back(mk(0,4'h0,4'h0,1,1,0,1,0, 0,16'h0000,1,0));
    // overwrite of ch2 while ch1 is stalled in SEND
    vec.push_back(mk(1,4'h0,4'h0,1,0,0,0,0, 0,16'h0000,0,0));
    vec.push_back(mk(0,4'h2,4'h3,0,0,0,0,0, 0,16'h0000,0,0));
    vec.push_back(mk(0,4'h4,4'h1,0,0,0,0,0, 0,16'h0000,1,0));
    vec.push_back(mk(0,4'h4,4'h0,0,0,0,0,0, 1,16'hA203,1,0));
    vec.push_back(mk(0,4'h0,4'h0,0,0,0,0,0, 1,16'hA203,1,0));
    vec.push_back(mk(0,4'h0,4'h0,1,0,0,0,0, 1,16'hA203,1,0));
    vec.push_back(mk(0,4'h0,4'h0,1,1,1,0,0, 0,16'h0000,1,0));
    vec.push_back(mk(0,4'h0,4'h0,1,0,0,0,0, 0,16'h0000,1,0));
    vec.push_back(mk(0,4'h0,4'h0,1,0,0,0,0, 1,16'hA400,1,0));
    vec.push_back(mk(0,4'h0,4'h0,1,1,2,0,0, 0,16'h0000,1,0));
    vec.push_back(mk(0,4'h0,4'h0,1,0,0,0,0, 0,16'h0000,0,0));
    // wrong acks ignored; capture to the in-flight channel re-arms it
    vec.push_back(mk(0,4'h1,4'h1,1,0,0,0,0, 0,16'h0000,0,0));
    vec.push_back(mk(0,4'h0,4'h0,1,0,0,0,0, 0,16'h0000,1,0));
    vec.push_back(mk(0,4'h0,4'h0,1,0,0,0,0, 1,16'hA001,1,0));
    vec.push_back(mk(0,4'h1,4'h2,1,1,1,0,0, 0,16'h0000,1,0));
    vec.push_back(mk(0,4'h0,4'h0,1,1,0,1,0, 0,16'h0000,1,0));
    vec.push_back(mk(0,4'h0,4'h0,1,1,0,0,0, 0,16'h0000,1,0));
    vec.push_back(mk(0,4'h0,4'h0,1,0,0,0,0, 0,16'h0000,1,0));
    vec.push_back(mk(0,4'h0,4'h0,1,0,0,0,0, 1,16'hA012,1,0));
    vec.push_back(mk(0,4'h0,4'h0,1,1,0,1,0, 0,16'h0000,1,0));
    vec.push_back(mk(0,4'h0,4'h0,1,0,0,0,0, 0,16'h0000,0,0));

    foreach (vec[i]) begin
      applyStimulus(vec[i], i);
      step();
    end
    link.ack_vld_i = 1'b0;

    // Timeout and retry on ch1: four sends, then a sticky error that beats a same-cycle clear
    doReset();
    link.tx_rdy_i = 1'b1;
    sel = 4'h2; cmd = 4'h1;
    step();
    sel = 4'h0;
    for (int s = 0; s < 4; s++) begin
      waitVld(40, gap);
      if (s == 0) begin
        checkOutput("first_send_latency", 16'(gap), 16'd1);
        checkOutput("first_send_word", link.tx_data_o, 16'hA201);
      end else begin
        checkOutput("retry_gap", 16'(gap), 16'd16);
        checkOutput("retry_word", link.tx_data_o, 16'hA301);
      end
      step();
    end
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      if (link.tx_vld_o) extra++;
      step();
    end
    checkOutput("no_fifth_send", 16'(extra), 16'd0);
    checkOutput("err_before_giveup", {13'd0, err}, 16'd0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checkOutput("err_set_beats_clr", {13'd0, err}, 16'h0002);
    checkOutput("busy_after_giveup", {15'd0, busy}, 16'd0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checkOutput("err_cleared", {13'd0, err}, 16'd0);
    sel = 4'h2; cmd = 4'h1;
    step();
    sel = 4'h0;
    waitVld(10, gap);
    checkOutput("seq_after_giveup", link.tx_data_o, 16'hA211);
    step();
    link.ack_vld_i = 1'b1; link.ack_ch_i = 2'd1; link.ack_seq_i = 4'd1;
    step();
    link.ack_vld_i = 1'b0;
    checkOutput("busy_after_ack", {15'd0, busy}, 16'd0);

    // Matching ack in the timeout cycle: no retry, no error, seq advances
    sel = 4'h1; cmd = 4'h1;
    step();
    sel = 4'h0;
    waitVld(10, gap);
    checkOutput("collide_word", link.tx_data_o, 16'hA001);
    step();
    repeat (15) step();
    link.ack_vld_i = 1'b1; link.ack_ch_i = 2'd0; link.ack_seq_i = 4'd0;
    step();
    link.ack_vld_i = 1'b0;
    checkOutput("collide_busy", {15'd0, busy}, 16'd0);
    checkOutput("collide_err", {13'd0, err}, 16'd0);
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      if (link.tx_vld_o) extra++;
      step();
    end
    checkOutput("collide_no_retry", 16'(extra), 16'd0);
    sel = 4'h1; cmd = 4'h1;
    step();
    sel = 4'h0;
    waitVld(10, gap);
    checkOutput("collide_seq", link.tx_data_o, 16'hA011);
    step();
    link.ack_vld_i = 1'b1; link.ack_ch_i = 2'd0; link.ack_seq_i = 4'd1;
    step();
    link.ack_vld_i = 1'b0;

    // Ack during SEND is ignored; reset mid-SEND abandons the frame
    link.tx_rdy_i = 1'b0;
    sel = 4'h4; cmd = 4'h2;
    step();
    sel = 4'h0;
    waitVld(10, gap);
    checkOutput("stall_word", link.tx_data_o, 16'hA402);
    link.ack_vld_i = 1'b1; link.ack_ch_i = 2'd2; link.ack_seq_i = 4'd0;
    step();
    link.ack_vld_i = 1'b0;
    checkOutput("ack_in_send_ignored", {15'd0, link.tx_vld_o}, 16'd1);
    doReset();
    checkOutput("rst_mid_vld", {15'd0, link.tx_vld_o}, 16'd0);
    checkOutput("rst_mid_busy", {15'd0, busy}, 16'd0);
    checkOutput("rst_mid_err", {13'd0, err}, 16'd0);
    checkOutput("rst_mid_data", link.tx_data_o, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
